// File: rtl/wam_sch.sv
// Whac-A-Mole scheduler: spawns moles from an LFSR gated by rto, ages them from age,
// retires them on hit or expiry, and sequences a fixed-length round (IDLE/RUN/DONE).
module wam_sch #(
  parameter int         MAXM       = 4,
  parameter int         GAME_TICKS = 600,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic        clk_19,
  input  logic        rst,
  input  logic        start,
  input  logic        tick,
  input  logic [3:0]  age,
  input  logic [7:0]  rto,
  input  logic [15:0] hit,
  output logic [15:0] mole,
  output logic [4:0]  act_cnt,
  output logic        hit_ok,
  output logic        miss,
  output logic        running,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [9:0] LAST_TICK = 10'(GAME_TICKS - 1);
  localparam logic [4:0] MAXM_L    = 5'(MAXM);

  state_t      state_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic [9:0]  rnd_q;
  logic [15:0] mole_q;
  logic [15:0] mole_d;
  logic [3:0]  cnt_q [16];
  logic [3:0]  cnt_d [16];
  logic        hit_ok_q;
  logic        miss_q;
  logic        running_q;
  logic        game_over_q;

  logic [15:0] mole_live;
  logic [4:0]  live_cnt;
  logic [4:0]  pop_cnt;
  logic [3:0]  spawn_h;
  logic [3:0]  age_eff;
  logic        hit_any;
  logic        exp_any;
  logic        spawn;
  logic        round_end;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign spawn_h   = lfsr_q[3:0];
  assign age_eff   = (age == 4'd0) ? 4'd1 : age;
  assign round_end = tick && (rnd_q == LAST_TICK);

  // Per-hole next state: hits first, then ageing/expiry on a tick, then at most one spawn.
  always_comb begin
    mole_live = mole_q;
    hit_any   = 1'b0;
    exp_any   = 1'b0;
    live_cnt  = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < 16; i++) begin
      if (hit[i] && mole_q[i]) begin
        mole_live[i] = 1'b0;
        cnt_d[i]     = 4'd0;
        hit_any      = 1'b1;
      end else if (tick && mole_q[i]) begin
        if (cnt_q[i] <= 4'd1) begin
          mole_live[i] = 1'b0;
          cnt_d[i]     = 4'd0;
          exp_any      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 4'd1;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      live_cnt = live_cnt + 5'(mole_live[i]);
    end
    // Blocking on the original mole and hit bits keeps a just-retired hole empty this cycle.
    spawn  = tick && (lfsr_q < rto) && !mole_q[spawn_h] && !hit[spawn_h] && (live_cnt < MAXM_L);
    mole_d = mole_live;
    if (spawn) begin
      mole_d[spawn_h] = 1'b1;
      cnt_d[spawn_h]  = age_eff;
    end
  end

  always_comb begin
    pop_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + 5'(mole_q[i]);
    end
  end

  always_ff @(posedge clk_19 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      rnd_q       <= 10'd0;
      mole_q      <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= 4'd0;
      end
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_RUN;
            running_q   <= 1'b1;
            game_over_q <= 1'b0;
            rnd_q       <= 10'd0;
            mole_q      <= 16'd0;
            for (int i = 0; i < 16; i++) begin
              cnt_q[i] <= 4'd0;
            end
          end
        end
        S_RUN: begin
          hit_ok_q <= hit_any;
          miss_q   <= exp_any;
          if (round_end) begin
            // Round counter is left at its last value while in DONE.
            state_q     <= S_DONE;
            running_q   <= 1'b0;
            game_over_q <= 1'b1;
            mole_q      <= 16'd0;
            for (int i = 0; i < 16; i++) begin
              cnt_q[i] <= 4'd0;
            end
          end else begin
            mole_q <= mole_d;
            cnt_q  <= cnt_d;
            if (tick) begin
              rnd_q <= rnd_q + 10'd1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          running_q   <= 1'b0;
          game_over_q <= 1'b0;
          mole_q      <= 16'd0;
        end
      endcase
    end
  end

  assign mole      = mole_q;
  assign act_cnt   = pop_cnt;
  assign hit_ok    = hit_ok_q;
  assign miss      = miss_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule
